// File: rtl/sdram_wr_sched_if.sv
// Write-scheduler bus: FIFO level/pop, arbiter request/grant and write-engine
// command/acknowledge signals shared between the scheduler and its neighbours.
interface sdram_wr_sched_if;
    logic [9:0]  fifo_used;
    logic        fifo_rd_en;
    logic        wr_req;
    logic        wr_grant;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [9:0]  wr_bst_len;
    logic        wr_ack;
    logic        wr_end;

    // Scheduler side
    modport master (
        input  fifo_used, wr_grant, wr_ack, wr_end,
        output fifo_rd_en, wr_req, wr_en, wr_addr, wr_bst_len
    );

    // FIFO / arbiter / engine side
    modport slave (
        output fifo_used, wr_grant, wr_ack, wr_end,
        input  fifo_rd_en, wr_req, wr_en, wr_addr, wr_bst_len
    );
endinterface

// File: rtl/sdram_wr_sched.sv
// SDRAM write-burst scheduler: launches bursts from the write FIFO fill level,
// clips each burst to the current 512-word row and the circular address
// window, arbitrates for the command bus and walks the window pointer.
module sdram_wr_sched #(
    parameter logic [9:0] BURST_LEN = 10'd64
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  init_end,
    input  logic [23:0]           cfg_base_addr,
    input  logic [23:0]           cfg_end_addr,
    input  logic                  cfg_load,
    input  logic                  flush,
    sdram_wr_sched_if.master      bus,
    output logic [23:0]           wr_ptr,
    output logic [15:0]           burst_cnt,
    output logic                  ack_err,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,      state_d;
    logic        wr_req_q,     wr_req_d;
    logic        wr_en_q,      wr_en_d;
    logic [23:0] wr_addr_q,    wr_addr_d;
    logic [9:0]  wr_bst_len_q, wr_bst_len_d;
    logic [23:0] wr_ptr_q,     wr_ptr_d;
    logic [15:0] burst_cnt_q,  burst_cnt_d;
    logic        ack_err_q,    ack_err_d;
    logic        load_pend_q,  load_pend_d;
    logic [9:0]  ack_cnt_q,    ack_cnt_d;

    logic [9:0]  avail;
    logic [9:0]  row_rem;
    logic [23:0] win_rem;
    logic [9:0]  len_row;
    logic [9:0]  len;
    logic        launch;
    logic [24:0] ptr_next;

    // Burst length and launch decision from FIFO level, row and window limits
    always_comb begin
        avail   = (bus.fifo_used >= BURST_LEN) ? BURST_LEN : {bus.fifo_used[9:1], 1'b0};
        row_rem = 10'd512 - {1'b0, wr_ptr_q[8:0]};
        win_rem = cfg_end_addr - wr_ptr_q + 24'd1;
        len_row = (avail < row_rem) ? avail : row_rem;
        len     = ({14'd0, len_row} > win_rem) ? win_rem[9:0] : len_row;
        launch  = init_end &&
                  ((bus.fifo_used >= BURST_LEN) || (flush && (bus.fifo_used >= 10'd2)));
        ptr_next = {1'b0, wr_ptr_q} + {15'd0, wr_bst_len_q};
    end

    // Next-state logic for the burst sequencer and window pointer
    always_comb begin
        state_d      = state_q;
        wr_req_d     = wr_req_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_bst_len_d = wr_bst_len_q;
        wr_ptr_d     = wr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        ack_err_d    = ack_err_q;
        load_pend_d  = load_pend_q;
        ack_cnt_d    = ack_cnt_q;

        // A reload requested mid-burst is deferred to the DONE pointer update
        if (cfg_load && (state_q != S_IDLE)) begin
            load_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    wr_ptr_d = cfg_base_addr;
                end else if (launch) begin
                    wr_addr_d    = wr_ptr_q;
                    wr_bst_len_d = len;
                    wr_req_d     = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.wr_grant) begin
                    wr_en_d   = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                ack_cnt_d = ack_cnt_q + {9'd0, bus.wr_ack};
                if (bus.wr_end) begin
                    wr_en_d  = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: begin
                if (ack_cnt_q != wr_bst_len_q) begin
                    ack_err_d = 1'b1;
                end
                burst_cnt_d = burst_cnt_q + 16'd1;
                if (load_pend_q || cfg_load) begin
                    wr_ptr_d    = cfg_base_addr;
                    load_pend_d = 1'b0;
                end else if (ptr_next > {1'b0, cfg_end_addr}) begin
                    wr_ptr_d = cfg_base_addr;
                end else begin
                    wr_ptr_d = ptr_next[23:0];
                end
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= S_IDLE;
            wr_req_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_bst_len_q <= BURST_LEN;
            wr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            ack_err_q    <= 1'b0;
            load_pend_q  <= 1'b0;
            ack_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_req_q     <= wr_req_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_bst_len_q <= wr_bst_len_d;
            wr_ptr_q     <= wr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            ack_err_q    <= ack_err_d;
            load_pend_q  <= load_pend_d;
            ack_cnt_q    <= ack_cnt_d;
        end
    end

    assign bus.wr_req     = wr_req_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_bst_len = wr_bst_len_q;
    assign bus.fifo_rd_en = (state_q == S_RUN) && bus.wr_ack;
    assign wr_ptr         = wr_ptr_q;
    assign burst_cnt      = burst_cnt_q;
    assign ack_err        = ack_err_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/sdram_wr_sched.md
# sdram_wr_sched

Write-burst scheduler that sequences the SDRAM write engine from a write FIFO. It watches the FIFO fill level, decides when to launch a burst and how long it is, and wins the command bus through the top-level arbiter. It then drives the engine's enable, address and burst-length inputs, and pops the FIFO on each engine data acknowledge. A region pointer walks a configurable circular address window; bursts never cross a 512-word row or the window end.

## Interface
- BURST_LEN, 10'd64: nominal burst length in words; must be even, 2..512.
- wr_clk  in  1  clock.
- wr_rst_n  in  1  reset; asynchronous, active-low.
- init_end  in  1  SDRAM init complete; no launch while low.
- cfg_base_addr  in  24  window start (word address); must be even.
- cfg_end_addr  in  24  window last word, inclusive; must be odd and greater than base.
- cfg_load  in  1  one-cycle pulse; reload the pointer to cfg_base_addr.
- fifo_used  in  10  words currently held in the write FIFO.
- flush  in  1  level signal; allow bursts shorter than BURST_LEN.
- fifo_rd_en  out  1  FIFO pop; equals wr_ack while in RUN, 0 otherwise.
- wr_req  out  1  arbiter request.
- wr_grant  in  1  arbiter grant.
- wr_en  out  1  write engine enable.
- wr_addr  out  24  burst start: {bank[23:22], row[21:9], col[8:0]}.
- wr_bst_len  out  10  burst length in words.
- wr_ack  in  1  engine data acknowledge; one per word.
- wr_end  in  1  engine burst-complete pulse.
- wr_ptr  out  24  current window pointer.
- burst_cnt  out  16  completed bursts; wraps at 16'hFFFF to 0.
- ack_err  out  1  sticky error: ack count differed from wr_bst_len at wr_end.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, REQ, RUN, DONE. All outputs are registered except fifo_rd_en and busy.
- Reset values:
  - state = IDLE.
  - wr_req = wr_en = 0.
  - wr_addr = 0, wr_bst_len = BURST_LEN.
  - wr_ptr = 0, burst_cnt = 0, ack_err = 0.
  - A pending load is cleared.
- Length computation, in IDLE and all unsigned:
  - avail = BURST_LEN if fifo_used >= BURST_LEN, else fifo_used with bit 0 cleared.
  - row_rem = 512 - wr_ptr[8:0].
  - win_rem = cfg_end_addr - wr_ptr + 1.
  - len = min(avail, row_rem, win_rem). Parity rules keep len even and at least 2.
- Launch condition: init_end && (fifo_used >= BURST_LEN || (flush && fifo_used >= 2)).
- A single residual word under flush is not issued; it waits for a second word.
- IDLE:
  - cfg_load has priority: wr_ptr <= cfg_base_addr, stay in IDLE that cycle.
  - Otherwise, on launch: wr_addr <= wr_ptr, wr_bst_len <= len, wr_req <= 1, go to REQ.
- REQ: hold wr_req. When wr_grant is sampled high: wr_en <= 1, go to RUN.
- RUN:
  - wr_en and wr_req stay high until wr_end is sampled.
  - Count wr_ack pulses into a 10-bit ack counter.
  - Deassertion of wr_grant is ignored; an engine burst cannot be aborted.
  - On wr_end: wr_en <= 0, wr_req <= 0, go to DONE.
  - If wr_ack and wr_end arrive in the same cycle, that ack is counted.
- DONE, one cycle:
  - If acks != wr_bst_len, set ack_err.
  - burst_cnt increments.
  - Pointer update:
    - If a load is pending: wr_ptr <= cfg_base_addr and the pending flag clears.
    - Else if wr_ptr + wr_bst_len > cfg_end_addr: wr_ptr <= cfg_base_addr (wrap).
    - Else: wr_ptr <= wr_ptr + wr_bst_len.
  - Go to IDLE.
- cfg_load seen outside IDLE sets the pending flag; the reload is applied in DONE.
- Asynchronous reset mid-burst returns to IDLE with all outputs at reset values; FIFO state is the caller's responsibility.

## Timing
- Launch condition true in IDLE at edge N: wr_req is high from N+1.
- wr_grant sampled high at edge M: wr_en is high from M+1.
- wr_end sampled at edge K:
  - wr_en and wr_req are low from K+1.
  - wr_ptr and burst_cnt update at K+2.
  - The earliest next wr_req is at K+3.
- fifo_rd_en is combinational from wr_ack, so the pop lands in the same cycle as the acknowledge.
- wr_addr and wr_bst_len are stable from the REQ entry edge until DONE exits.

## Test plan
- Window 0x000000–0x0003FF, fifo_used = 64, immediate grant:
  - wr_addr = 0x000000, wr_bst_len = 64, 64 fifo_rd_en pulses.
  - After DONE: wr_ptr = 0x000040, burst_cnt = 1.
- wr_ptr = 0x0001F0, fifo_used = 100 -> wr_bst_len = 16 (row clip), next wr_ptr = 0x000200.
- Window 0x000100–0x00013F, wr_ptr = 0x000120, fifo_used = 64 -> wr_bst_len = 32, wr_ptr wraps to 0x000100.
- flush = 1, fifo_used = 7 -> wr_bst_len = 6. Then with fifo_used = 1 and flush held: no wr_req for 100 cycles.
- Grant delayed 20 cycles, and cfg_load pulsed during RUN:
  - wr_en rises exactly 1 cycle after grant.
  - wr_ptr becomes cfg_base_addr after DONE.
- Engine returns 63 acks for a 64-word burst -> ack_err = 1 and stays high until reset. Reset asserted mid-RUN -> all outputs at reset values the next cycle.
